// File: rtl/wb_tia_audio.sv
// wb_tia_audio
//   Wishbone-mapped, N-channel TIA-style sound generator. Each channel has
//   AUDC (mode), AUDF (divider) and AUDV (volume) registers. A divider feeds
//   the channel's polynomial counters or tone flop. On every audio tick the
//   channel outputs are mixed into an unsigned sample. A first-order
//   sigma-delta modulator turns that sample into a 1-bit PDM pin.
//
// Ports
//   clk_i           system clock
//   rst_i           synchronous active-high reset
//   stb_i, we_i     bus strobe / write enable (1 = write)
//   adr_i, dat_i    register address / write data
//   ack_o           bus acknowledge, one cycle after the strobe
//   dat_o           read data (zero-extended register value, 0 if unmapped)
//   sample_o        mixed sample, 0 .. 15*NUM_CHANNELS
//   sample_valid_o  one-cycle pulse when sample_o updates
//   pdm_o           sigma-delta bitstream
//
// Register map, channel c: 0x40+4c AUDC, +1 AUDF, +2 AUDV, +3 out_c (read-only).
// With COMPAT set, 0x15/0x16 AUDC0/1, 0x17/0x18 AUDF0/1 and 0x19/0x1A AUDV0/1 alias channels 0/1.
module wb_tia_audio #(
    parameter int WB_DATA_WIDTH = 8,
    parameter int WB_ADDR_WIDTH = 7,
    parameter int NUM_CHANNELS  = 2,
    parameter int CLK_DIV       = 512,
    parameter int COMPAT        = 1,
    localparam int SW           = 4 + $clog2(NUM_CHANNELS + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     stb_i,
    input  logic                     we_i,
    input  logic [WB_ADDR_WIDTH-1:0] adr_i,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    output logic                     ack_o,
    output logic [WB_DATA_WIDTH-1:0] dat_o,
    output logic [SW-1:0]            sample_o,
    output logic                     sample_valid_o,
    output logic                     pdm_o
);

    localparam int AW = WB_ADDR_WIDTH;
    localparam int DW = WB_DATA_WIDTH;
    localparam int NC = NUM_CHANNELS;
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [PW-1:0] presc;
    logic          tick;

    logic [3:0] audc   [NC];
    logic [4:0] audf   [NC];
    logic [3:0] audv   [NC];
    logic [4:0] divcnt [NC];
    logic [1:0] div3   [NC];
    logic [3:0] poly4  [NC];
    logic [4:0] poly5  [NC];
    logic [8:0] poly9  [NC];
    logic [4:0] cnt31  [NC];
    logic       tone   [NC];

    logic [NC-1:0] chan_out;
    logic [NC-1:0] step;
    logic [NC-1:0] sel_audc, sel_audf, sel_audv, sel_out;
    logic [DW-1:0] rd_data;
    logic [SW-1:0] mix_sum;
    logic [SW-1:0] pdm_acc;

    // Registers only use the low five data bits.
    logic unused_dat;
    assign unused_dat = ^dat_i;

    function automatic logic [3:0] poly4_next(input logic [3:0] p);
        return {p[2:0], p[3] ^ p[2]};
    endfunction

    function automatic logic [4:0] poly5_next(input logic [4:0] p);
        return {p[3:0], p[4] ^ p[2]};
    endfunction

    function automatic logic [8:0] poly9_next(input logic [8:0] p);
        return {p[7:0], p[8] ^ p[4]};
    endfunction

    function automatic logic [4:0] cnt31_next(input logic [4:0] n);
        return (n == 5'd30) ? 5'd0 : n + 5'd1;
    endfunction

    function automatic logic mode_out(input logic [3:0] mode, input logic [3:0] p4,
                                      input logic [4:0] p5, input logic [8:0] p9,
                                      input logic [4:0] c31, input logic t);
        logic o;
        case (mode)
            4'd1:                             o = p4[3];
            4'd2, 4'd3, 4'd7, 4'd9, 4'd15:    o = p5[4];
            4'd4, 4'd5, 4'd12, 4'd13:         o = t;
            4'd6, 4'd10, 4'd14:               o = (c31 < 5'd15);
            4'd8:                             o = p9[8];
            default:                          o = 1'b1;
        endcase
        return o;
    endfunction

    // The sum cannot exceed 15*NC, which SW is sized to hold.
    function automatic logic [SW-1:0] mix_add(input logic [SW-1:0] acc, input logic on,
                                              input logic [3:0] vol);
        return on ? acc + SW'(vol) : acc;
    endfunction

    assign tick = (presc == PW'(CLK_DIV - 1));

    always_comb begin
        sel_audc = '0;
        sel_audf = '0;
        sel_audv = '0;
        sel_out  = '0;
        for (int c = 0; c < NC; c++) begin
            sel_audc[c] = (adr_i == AW'(32'h40 + 4 * c));
            sel_audf[c] = (adr_i == AW'(32'h41 + 4 * c));
            sel_audv[c] = (adr_i == AW'(32'h42 + 4 * c));
            sel_out[c]  = (adr_i == AW'(32'h43 + 4 * c));
        end
        if (COMPAT != 0) begin
            for (int c = 0; c < NC && c < 2; c++) begin
                if (adr_i == AW'(32'h15 + c)) sel_audc[c] = 1'b1;
                if (adr_i == AW'(32'h17 + c)) sel_audf[c] = 1'b1;
                if (adr_i == AW'(32'h19 + c)) sel_audv[c] = 1'b1;
            end
        end
    end

    always_comb begin
        chan_out = '0;
        step     = '0;
        mix_sum  = '0;
        rd_data  = '0;
        for (int c = 0; c < NC; c++) begin
            chan_out[c] = mode_out(audc[c], poly4[c], poly5[c], poly9[c], cnt31[c], tone[c]);
            // A lowered AUDF leaves divcnt above it, so >= forces the step.
            step[c]     = tick && (divcnt[c] >= audf[c]);
            // Mixing uses the outputs as they stand before this tick's step.
            mix_sum     = mix_add(mix_sum, chan_out[c], audv[c]);
            if (sel_audc[c]) rd_data = DW'(audc[c]);
            if (sel_audf[c]) rd_data = DW'(audf[c]);
            if (sel_audv[c]) rd_data = DW'(audv[c]);
            if (sel_out[c])  rd_data = DW'(chan_out[c]);
        end
    end

    // Bus response stage
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_o <= 1'b0;
            dat_o <= '0;
        end else begin
            ack_o <= stb_i;
            dat_o <= (stb_i && !we_i) ? rd_data : '0;
        end
    end

    // Registers and per-channel generators; a step always sees the mode held before this edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NC; c++) begin
                audc[c]   <= '0;
                audf[c]   <= '0;
                audv[c]   <= '0;
                divcnt[c] <= '0;
                div3[c]   <= '0;
                poly4[c]  <= 4'hF;
                poly5[c]  <= 5'h1F;
                poly9[c]  <= 9'h1FF;
                cnt31[c]  <= '0;
                tone[c]   <= 1'b0;
            end
        end else begin
            for (int c = 0; c < NC; c++) begin
                if (stb_i && we_i) begin
                    if (sel_audc[c]) audc[c] <= dat_i[3:0];
                    if (sel_audf[c]) audf[c] <= dat_i[4:0];
                    if (sel_audv[c]) audv[c] <= dat_i[3:0];
                end
                if (tick) divcnt[c] <= step[c] ? 5'd0 : divcnt[c] + 5'd1;
                if (step[c]) begin
                    div3[c] <= (div3[c] == 2'd2) ? 2'd0 : div3[c] + 2'd1;
                    case (audc[c])
                        4'd1:                   poly4[c] <= poly4_next(poly4[c]);
                        4'd2, 4'd3, 4'd7, 4'd9: poly5[c] <= poly5_next(poly5[c]);
                        4'd15: if (div3[c] == 2'd2) poly5[c] <= poly5_next(poly5[c]);
                        4'd4, 4'd5:             tone[c]  <= ~tone[c];
                        4'd12, 4'd13: if (div3[c] == 2'd2) tone[c] <= ~tone[c];
                        4'd6, 4'd10:            cnt31[c] <= cnt31_next(cnt31[c]);
                        4'd14: if (div3[c] == 2'd2) cnt31[c] <= cnt31_next(cnt31[c]);
                        4'd8:                   poly9[c] <= poly9_next(poly9[c]);
                        default: ;
                    endcase
                end
            end
        end
    end

    // Prescaler, mix and sigma-delta stage
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc          <= '0;
            sample_o       <= '0;
            sample_valid_o <= 1'b0;
            pdm_acc        <= '0;
            pdm_o          <= 1'b0;
        end else begin
            presc          <= tick ? '0 : presc + PW'(1);
            sample_valid_o <= tick;
            if (tick) sample_o <= mix_sum;
            // The carry out of the accumulator is the PDM bit.
            {pdm_o, pdm_acc} <= {1'b0, pdm_acc} + {1'b0, sample_o};
        end
    end

endmodule

// File: tb/tb_wb_tia_audio.sv
module tb_wb_tia_audio;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       stb_i = 1'b0;
    logic       we_i  = 1'b0;
    logic [6:0] adr_i = '0;
    logic [7:0] dat_i = '0;
    logic       ack_o;
    logic [7:0] dat_o;
    logic [5:0] sample_o;
    logic       sample_valid_o;
    logic       pdm_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_q[$];
    int unsigned edges;
    int          gap = 0;
    bit          have_last = 0;

    always #5 clk_i = ~clk_i;

    wb_tia_audio #(
        .WB_DATA_WIDTH(8),
        .WB_ADDR_WIDTH(7),
        .NUM_CHANNELS(2),
        .CLK_DIV(4),
        .COMPAT(1)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .stb_i(stb_i),
        .we_i(we_i),
        .adr_i(adr_i),
        .dat_i(dat_i),
        .ack_o(ack_o),
        .dat_o(dat_o),
        .sample_o(sample_o),
        .sample_valid_o(sample_valid_o),
        .pdm_o(pdm_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Bench-side count of clock edges since reset release; ticks fall on multiples of 4.
    always @(posedge clk_i) begin
        if (rst_i) edges <= 0;
        else       edges <= edges + 1;
    end

    // Scoreboard consumer: one expected sample per valid pulse while entries are queued.
    always @(negedge clk_i) begin
        if (rst_i) begin
            have_last = 0;
            gap = 0;
        end else begin
            gap++;
            if (sample_valid_o) begin
                if (have_last) check("tick spacing", gap, 4);
                have_last = 1;
                gap = 0;
                if (exp_q.size() > 0) check("sample", sample_o, exp_q.pop_front());
            end
        end
    end

    task automatic do_reset(input int cycles);
        @(negedge clk_i);
        rst_i = 1'b1;
        stb_i = 1'b0;
        we_i  = 1'b0;
        repeat (cycles) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic bus_write(input logic [6:0] a, input logic [7:0] d, input int pre);
        repeat (pre) @(negedge clk_i);
        @(negedge clk_i);
        check("ack idle before write", ack_o, 0);
        stb_i = 1'b1;
        we_i  = 1'b1;
        adr_i = a;
        dat_i = d;
        @(negedge clk_i);
        check("write ack", ack_o, 1);
        stb_i = 1'b0;
        we_i  = 1'b0;
    endtask

    task automatic bus_read(input logic [6:0] a, output logic [7:0] d);
        @(negedge clk_i);
        check("ack idle before read", ack_o, 0);
        stb_i = 1'b1;
        we_i  = 1'b0;
        adr_i = a;
        @(negedge clk_i);
        check("read ack", ack_o, 1);
        d = dat_o;
        stb_i = 1'b0;
    endtask

    // Returns 1 time unit after the negedge that follows a tick edge.
    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!sample_valid_o && n < 100);
        if (!sample_valid_o) check("tick timeout", sample_valid_o, 1);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk_i);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("scoreboard drain", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        int         ones;
        int         k;
        int         d;
        bit         t;
        logic [6:0] zero_addrs [6];
        int         p4_exp [16];

        zero_addrs = '{7'h40, 7'h41, 7'h42, 7'h44, 7'h45, 7'h46};
        p4_exp     = '{1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 1, 0, 1};

        // Reset values and register readback
        do_reset(2);
        check("reset ack_o", ack_o, 0);
        check("reset dat_o", dat_o, 0);
        check("reset sample_o", sample_o, 0);
        check("reset sample_valid_o", sample_valid_o, 0);
        check("reset pdm_o", pdm_o, 0);
        foreach (zero_addrs[i]) begin
            bus_read(zero_addrs[i], rd);
            check("reset reg read", rd, 0);
        end

        // Bus map, aliases, unmapped space, out_c readback
        bus_write(7'h41, 8'hFF, 0);
        @(negedge clk_i);
        check("ack single cycle", ack_o, 0);
        bus_read(7'h41, rd);
        check("AUDF0 readback", rd, 8'h1F);
        bus_read(7'h7C, rd);
        check("unmapped 0x7C", rd, 0);
        bus_read(7'h17, rd);
        check("compat AUDF0 read", rd, 8'h1F);
        bus_write(7'h19, 8'hFF, 0);
        bus_read(7'h42, rd);
        check("compat AUDV0 write", rd, 8'h0F);
        bus_write(7'h48, 8'h05, 0);
        bus_read(7'h48, rd);
        check("channel 2 unmapped", rd, 0);
        bus_read(7'h43, rd);
        check("out0 mode 0", rd, 1);

        // Reset asserted with a live sample clears it on the next edge
        do_reset(2);
        bus_write(7'h42, 8'd15, 0);
        wait_tick();
        check("sample before reset", sample_o, 15);
        do_reset(1);
        check("mid-tone reset sample_o", sample_o, 0);
        check("mid-tone reset valid", sample_valid_o, 0);

        // Tone mode, AUDF 0 then 3
        do_reset(2);
        bus_write(7'h42, 8'd15, 0);
        wait_tick();
        for (int i = 0; i < 6; i++) exp_q.push_back((i % 2 == 0) ? 0 : 15);
        bus_write(7'h40, 8'd4, 0);
        wait_drain();
        wait_tick();
        for (int i = 0; i < 8; i++) exp_q.push_back((i < 4) ? 15 : 0);
        bus_write(7'h41, 8'd3, 0);
        wait_drain();

        // poly4 sequence from reset
        do_reset(2);
        bus_write(7'h42, 8'd1, 0);
        wait_tick();
        foreach (p4_exp[i]) exp_q.push_back(p4_exp[i]);
        bus_write(7'h40, 8'd1, 0);
        wait_drain();

        // Constant outputs mixed, then PDM density
        do_reset(2);
        bus_write(7'h42, 8'd15, 0);
        bus_write(7'h46, 8'd9, 0);
        wait_tick();
        exp_q.push_back(24);
        exp_q.push_back(24);
        wait_drain();
        for (int w = 0; w < 2; w++) begin
            ones = 0;
            repeat (64) begin
                @(negedge clk_i);
                ones += int'(pdm_o);
            end
            check("pdm ones per 64", ones, 24);
        end

        // Slow tone: toggles only on every third step
        do_reset(2);
        bus_write(7'h42, 8'd15, 0);
        wait_tick();
        check("tick phase", edges % 4, 0);
        k = int'(edges / 4);
        d = k % 3;
        t = 1'b0;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(t ? 15 : 0);
            if (d == 2) t = ~t;
            d = (d + 1) % 3;
        end
        bus_write(7'h40, 8'd12, 0);
        wait_drain();

        // AUDC write landing on a step edge: that step still runs the old mode
        do_reset(2);
        bus_write(7'h42, 8'd15, 0);
        wait_tick();
        exp_q.push_back(15);
        exp_q.push_back(0);
        exp_q.push_back(15);
        exp_q.push_back(0);
        bus_write(7'h40, 8'd4, 2);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
